approx_acc_16: RTL and testbench

// Streaming accumulator directly downstream of the 16x16 approximate multiplier. Consumes its

---
 rtl/approx_pkg.sv | 9 +
 rtl/approx_sat_add.sv | 18 +
 rtl/approx_acc_16.sv | 92 +++++++++
 tb/tb_approx_acc_16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared constants and FSM encoding for the approximate-multiplier datapath.
package approx_pkg;
  localparam int PROD_W = 16;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;
endpackage

// File: rtl/approx_sat_add.sv
// Unsigned W-bit + PROD_W-bit saturating adder; pure combinational.
import approx_pkg::*;

module approx_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0]      a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [W-1:0]      sum_o,
  output logic              ovf_o
);
  logic [W:0] full;

  // One extra bit catches the carry out of the W-bit accumulator.
  assign full  = {1'b0, a_i} + {{(W + 1 - PROD_W){1'b0}}, b_i};
  assign ovf_o = full[W];
  assign sum_o = ovf_o ? {W{1'b1}} : full[W-1:0];
endmodule

// File: rtl/approx_acc_16.sv
// Packetised saturating accumulator for the multiplier's truncated product stream.
// Beats are registered once before the fold; one result per packet on a valid/ready port.
import approx_pkg::*;

module approx_acc_16 #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 64,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] p_in,
  input  logic              p_valid,
  input  logic              p_last,
  output logic              p_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  sum_cnt,
  output logic              sum_sat,
  output logic              sum_valid,
  input  logic              sum_ready
);
  state_e              state_q;
  logic [PROD_W-1:0]   p_q;
  logic                last_q;
  logic                v_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                sat_q;
  logic                sat_d;
  logic                ovf;
  logic                end_pending;
  logic                accept;

  approx_sat_add #(.W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (p_q),
    .sum_o (acc_d),
    .ovf_o (ovf)
  );

  // The beat sitting in the capture register closes the packet, so stop accepting now.
  assign end_pending = v_q && (last_q || (cnt_q == CNT_W'(MAX_LEN - 1)));
  assign p_ready     = rst_n && (state_q == ACC) && !end_pending;
  assign accept      = p_valid && p_ready;

  assign cnt_d = cnt_q + 1'b1;
  assign sat_d = sat_q | ovf;

  assign sum_valid = (state_q == DONE);
  assign sum_out   = sum_valid ? acc_q : '0;
  assign sum_cnt   = sum_valid ? cnt_q : '0;
  assign sum_sat   = sum_valid & sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      p_q     <= '0;
      last_q  <= 1'b0;
      v_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      v_q <= accept;
      if (accept) begin
        p_q    <= p_in;
        last_q <= p_last;
      end
      case (state_q)
        ACC: begin
          if (v_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (end_pending) state_q <= DONE;
          end
        end
        DONE: begin
          if (sum_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_approx_acc_16.sv
// Randomised bench for approx_acc_16: default 24-bit instance plus a 17-bit one that saturates easily.
module tb_approx_acc_16;
  localparam int MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] p_in;
  logic        p_valid;
  logic        p_last;
  logic        sum_ready;

  logic        p_ready, sum_valid, sum_sat;
  logic [23:0] sum_out;
  logic [6:0]  sum_cnt;
  logic        p_ready17, sum_valid17, sum_sat17;
  logic [16:0] sum_out17;
  logic [6:0]  sum_cnt17;

  always #5 clk = ~clk;

  approx_acc_16 u_dut (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready), .sum_out(sum_out), .sum_cnt(sum_cnt), .sum_sat(sum_sat),
    .sum_valid(sum_valid), .sum_ready(sum_ready)
  );

  approx_acc_16 #(.ACC_W(17)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready17), .sum_out(sum_out17), .sum_cnt(sum_cnt17), .sum_sat(sum_sat17),
    .sum_valid(sum_valid17), .sum_ready(sum_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one open packet as a plain integer total, at most one finished packet waiting.
  longint cur_sum = 0;
  int     cur_cnt = 0;
  bit     pend = 1'b0;
  int     pend_cyc = 0;
  longint pend_sum = 0;
  int     pend_cnt = 0;
  int     cyc = 0;
  bit     armed = 1'b0;
  bit     acc_flag, hs_flag;
  logic [31:0] cap_sum, cap_cnt, cap_sat, cap_sum17, cap_sat17;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint clip(input longint s, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [15:0] d, input logic l,
                       input logic sr, input logic rn);
    bit exp_rdy, exp_sv;
    @(negedge clk);
    p_valid = v; p_in = d; p_last = l; sum_ready = sr; rst_n = rn;
    #1;
    cyc++;
    exp_rdy = rn && !pend;
    exp_sv  = pend && (cyc - pend_cyc >= 2);
    acc_flag = 1'b0;
    hs_flag  = 1'b0;
    if (armed) begin
      check("p_ready", p_ready, exp_rdy);
      check("p_ready17", p_ready17, exp_rdy);
      check("sum_valid", sum_valid, exp_sv);
      check("sum_valid17", sum_valid17, exp_sv);
      if (exp_sv) begin
        check("sum_out", sum_out, 32'(clip(pend_sum, 24)));
        check("sum_cnt", sum_cnt, pend_cnt);
        check("sum_sat", sum_sat, pend_sum > 64'hFFFFFF);
        check("sum_out17", sum_out17, 32'(clip(pend_sum, 17)));
        check("sum_cnt17", sum_cnt17, pend_cnt);
        check("sum_sat17", sum_sat17, pend_sum > 64'h1FFFF);
      end
    end
    if (!rn) begin
      cur_sum = 0; cur_cnt = 0; pend = 1'b0;
    end else begin
      if (exp_sv && sr) begin
        hs_flag = 1'b1;
        cap_sum = sum_out; cap_cnt = sum_cnt; cap_sat = sum_sat;
        cap_sum17 = sum_out17; cap_sat17 = sum_sat17;
        pend = 1'b0;
      end
      if (v && exp_rdy) begin
        acc_flag = 1'b1;
        cur_sum += d;
        cur_cnt++;
        if (l || cur_cnt == MAX_LEN) begin
          pend = 1'b1; pend_cyc = cyc; pend_sum = cur_sum; pend_cnt = cur_cnt;
          cur_sum = 0; cur_cnt = 0;
        end
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, d, l, 1'b1, 1'b1);
      if (acc_flag) break;
    end
    check("send_accept", acc_flag, 1'b1);
  endtask

  task automatic wait_result();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      if (hs_flag) break;
    end
    check("result_seen", hs_flag, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; p_valid = 1'b0; p_in = '0; p_last = 1'b0; sum_ready = 1'b0;

    // Reset held two cycles with a beat offered: nothing accepted.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    armed = 1'b1;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_cnt", sum_cnt, 0);
    check("rst_sum_sat", sum_sat, 0);

    // Short packet, then the 17-bit instance saturates on three full-scale beats.
    send_beat(16'h1000, 1'b0);
    send_beat(16'h2000, 1'b0);
    send_beat(16'h0001, 1'b1);
    wait_result();
    check("t2_sum", cap_sum, 32'h003001);
    check("t2_cnt", cap_cnt, 3);
    check("t2_sat", cap_sat, 0);

    for (int i = 0; i < 3; i++) send_beat(16'hFFFF, i == 2);
    wait_result();
    check("t3_sum17", cap_sum17, 32'h1FFFF);
    check("t3_sat17", cap_sat17, 1);
    check("t3_sum24", cap_sum, 32'h2FFFD);
    check("t3_sat24", cap_sat, 0);

    // Packet closed by length alone.
    for (int i = 0; i < MAX_LEN; i++) send_beat(16'h0001, 1'b0);
    wait_result();
    check("t4_sum", cap_sum, 64);
    check("t4_cnt", cap_cnt, 64);

    // Result held while the consumer stalls, then a fresh packet starts from zero.
    send_beat(16'h0007, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'h0009, 1'b1, 1'b0, 1'b1);
    wait_result();
    check("t5_hold_sum", cap_sum, 7);
    send_beat(16'h0005, 1'b1);
    wait_result();
    check("t5_sum", cap_sum, 5);
    check("t5_cnt", cap_cnt, 1);
    check("t5_sat", cap_sat, 0);

    // Reset mid-packet drops the partial sum.
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0100, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    send_beat(16'h0002, 1'b1);
    wait_result();
    check("t6_sum", cap_sum, 2);
    check("t6_cnt", cap_cnt, 1);

    // Random traffic with random consumer stalls and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                      : 16'($urandom_range(0, 16'hFFFF));
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 299) != 0);
    end
    if (pend) wait_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
